// File: rtl/div_master_pkg.sv
// div_master_pkg: FSM state encoding and response error codes
// shared by the divider front-end and its bench.
package div_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/div_master_if.sv
// div_master_if: command, divider and response signals of div_master.
// master = the div_master side, slave = the environment side.
interface div_master_if #(
    parameter int W = 32
) ();

    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_dvnd;
    logic [W-1:0] cmd_dvsr;

    logic         div_start;
    logic [W-1:0] div_dvnd;
    logic [W-1:0] div_dvsr;
    logic         div_ready;
    logic         div_done_tick;
    logic [W-1:0] div_quo;
    logic [W-1:0] div_rmd;

    logic         rsp_valid;
    logic [W-1:0] rsp_quo;
    logic [W-1:0] rsp_rmd;
    logic [1:0]   rsp_err;
    logic         rsp_ack;

    modport master (
        input  cmd_valid, cmd_dvnd, cmd_dvsr,
        output cmd_ready,
        output div_start, div_dvnd, div_dvsr,
        input  div_ready, div_done_tick, div_quo, div_rmd,
        output rsp_valid, rsp_quo, rsp_rmd, rsp_err,
        input  rsp_ack
    );

    modport slave (
        output cmd_valid, cmd_dvnd, cmd_dvsr,
        input  cmd_ready,
        input  div_start, div_dvnd, div_dvsr,
        output div_ready, div_done_tick, div_quo, div_rmd,
        input  rsp_valid, rsp_quo, rsp_rmd, rsp_err,
        output rsp_ack
    );

endinterface

// File: rtl/div_master_timer.sv
// div_timer: cycle counter for the WAIT state, flags the last
// cycle before a timeout.
module div_timer #(
    parameter int TO_CYC = 64
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TO_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CW'(TO_CYC - 1));

    // Holds at terminal count so it can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_master.sv
// div_master: accepts divide commands, drives an external divider
// and returns quotient/remainder with div-by-zero and timeout errors.
module div_master
    import div_master_pkg::*;
#(
    parameter int W      = 32,
    parameter int TO_CYC = 64
) (
    input logic         clk,
    input logic         reset_n,
    div_master_if.master bus
);

    state_e       state_q, state_d;
    logic [W-1:0] dvnd_q, dvnd_d;
    logic [W-1:0] dvsr_q, dvsr_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] rmd_q, rmd_d;
    logic [1:0]   err_q, err_d;
    logic         tmr_tc;

    div_timer #(
        .TO_CYC (TO_CYC)
    ) u_timer (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .clr_i    (state_q != WAIT),
        .en_i     (state_q == WAIT),
        .tc_o     (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dvnd_q  <= '0;
            dvsr_q  <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            dvnd_q  <= dvnd_d;
            dvsr_q  <= dvsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvnd_d  = dvnd_q;
        dvsr_d  = dvsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_dvsr != '0) begin
                        dvnd_d  = bus.cmd_dvnd;
                        dvsr_d  = bus.cmd_dvsr;
                        state_d = ISSUE;
                    end else begin
                        quo_d   = '1;
                        rmd_d   = bus.cmd_dvnd;
                        err_d   = ERR_DIV0;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                if (bus.div_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A done tick on the terminal cycle still wins.
                if (bus.div_done_tick) begin
                    quo_d   = bus.div_quo;
                    rmd_d   = bus.div_rmd;
                    err_d   = ERR_OK;
                    state_d = RESP;
                end else if (tmr_tc) begin
                    quo_d   = '0;
                    rmd_d   = '0;
                    err_d   = ERR_TMO;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.div_start = (state_q == ISSUE) && bus.div_ready;
    assign bus.div_dvnd  = dvnd_q;
    assign bus.div_dvsr  = dvsr_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_quo   = quo_q;
    assign bus.rsp_rmd   = rmd_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: doc/div_master.md
DIV_MASTER -- requirements
Module: div_master

Interface
REQ-001 SHALL have parameter W, default 32: operand/result width in bits.
REQ-002 SHALL have parameter TO_CYC, default 64: max cycles in WAIT before timeout, must be >= 2.
REQ-003 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1: synchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1: command request.
REQ-006 SHALL have port cmd_ready  output  1: command accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have ports cmd_dvnd, cmd_dvsr  input  W: dividend, divisor.
REQ-008 SHALL have ports div_start  output  1, div_dvnd, div_dvsr  output  W: drive the divider.
REQ-009 SHALL have ports div_ready, div_done_tick  input  1, div_quo, div_rmd  input  W: divider status and results.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_quo, rsp_rmd  output  W, rsp_err  output  2: response (00 ok, 01 divide-by-zero, 10 timeout).
REQ-011 SHALL have port rsp_ack  input  1: response consumed when rsp_valid & rsp_ack.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-013 cmd_ready SHALL be 1 only in IDLE, registered from state.
REQ-014 In IDLE, on handshake with cmd_dvsr != 0: operands latched into div_dvnd/div_dvsr, next state ISSUE.
REQ-015 In IDLE, on handshake with cmd_dvsr == 0: next state RESP, rsp_quo = all ones, rsp_rmd = cmd_dvnd, rsp_err = 01, div_start never asserted.
REQ-016 In ISSUE, div_start SHALL be 1 for exactly the first cycle where div_ready = 1; next state WAIT; otherwise remain in ISSUE with div_start 0.
REQ-017 div_dvnd/div_dvsr SHALL stay stable from ISSUE entry until return to IDLE.
REQ-018 In WAIT, a cycle counter SHALL clear on entry and increment each cycle.
REQ-019 In WAIT, on div_done_tick = 1: div_quo/div_rmd captured into rsp_quo/rsp_rmd, rsp_err = 00, next state RESP.
REQ-020 In WAIT, when the counter reaches TO_CYC-1 without div_done_tick: rsp_quo = 0, rsp_rmd = 0, rsp_err = 10, next state RESP.
REQ-021 div_done_tick in the same cycle as terminal count SHALL win (err 00).
REQ-022 div_done_tick in IDLE, ISSUE or RESP SHALL be ignored.
REQ-023 In RESP, rsp_valid SHALL be 1 with rsp_* held stable; on rsp_ack, next state IDLE.
REQ-024 rsp_ack while rsp_valid = 0 SHALL be ignored.
REQ-025 A new command SHALL be accepted no earlier than the cycle after a response handshake; no queuing.
REQ-026 Latency, ok path with div_ready high: handshake cycle N; div_start in N+1; rsp_valid the cycle after div_done_tick.
REQ-027 Latency, div-by-zero path: rsp_valid in cycle N+1.

Reset
REQ-028 While reset_n = 0 at a clock edge: state IDLE, cmd_ready 1 on the next cycle, div_start 0, rsp_valid 0, rsp_err 00, rsp_quo/rsp_rmd/div_dvnd/div_dvsr 0, counter 0.
REQ-029 Reset mid-operation (ISSUE, WAIT or RESP) SHALL abort with no response; a later div_done_tick is ignored.

Structure
REQ-030 Shared package div_master_pkg SHALL hold the state enum and the rsp_err codes (ERR_OK, ERR_DIV0, ERR_TMO).
REQ-031 The timeout counter SHALL be sub-module div_timer (clear, enable, terminal-count output, parameter TO_CYC).

Verification
REQ-032 dvnd = 100, dvsr = 7, model divider: one div_start pulse; rsp_quo = 14, rsp_rmd = 2, rsp_err = 00.
REQ-033 dvnd = 100, dvsr = 0: no div_start; rsp_valid at N+1; rsp_quo = 0xFFFFFFFF, rsp_rmd = 100, rsp_err = 01.
REQ-034 div_ready low 5 cycles after accept: div_start delayed until div_ready rises; exactly one pulse; operands stable.
REQ-035 div_done_tick never arrives, TO_CYC = 64: rsp_err = 10 with rsp_valid 64 cycles after WAIT entry; div_done_tick on the terminal cycle gives err 00.
REQ-036 rsp_ack held low 10 cycles, cmd_valid high: rsp_* stable, cmd_ready 0; second command accepted the cycle after rsp_ack.
REQ-037 reset_n low for 1 cycle during WAIT: outputs at reset values; late div_done_tick produces no rsp_valid.
